multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control unit sitting directly upstream of the MIPS datapath.
- Consumes the datapath's opcode and exception flags (overflow_error, reg_access). Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives regWrite and memWrite into the datapath, plus PC-advance and instruction-register load strobes.
- Halts stickily on illegal opcode, ALU overflow, register access error, or data-memory timeout.

Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in MEM waiting for mem_ready before a bus-error halt (legal range 1..255).
- RETIRE_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- opcode  in  6  instruction[31:26] from the datapath.
- overflow_error  in  1  ALU overflow flag from the datapath.
- reg_access  in  1  register-file access error from the datapath.
- mem_ready  in  1  data memory ready/ack for the current access.
- regWrite  out  1  register-file write enable.
- memWrite  out  1  data-memory write strobe.
- ir_load  out  1  latch instruction/opcode this cycle.
- pc_en  out  1  advance PC this cycle (instruction retires).
- state  out  3  current FSM state (debug).
- halted  out  1  sticky halt indicator.
- exc_cause  out  3  halt cause: 0 none, 1 illegal, 2 overflow, 3 regerr, 4 buserr.
- retired  out  RETIRE_W  count of retired instructions.

Behaviour:
- Reset (async, while high):
  - state=BOOT, halted=0, exc_cause=0, retired=0, class register=NONE, timeout counter=0.
  - All strobes 0.
- BOOT: all strobes 0. Next state is FETCH unconditionally (1 cycle).
- FETCH: ir_load=1. Next state is DECODE.
- DECODE: latches opcode class into a register. Opcode must not be re-sampled after DECODE.
  - 000000 -> RTYPE.
  - 00010x -> BRANCH.
  - 00001x -> JUMP.
  - 001xxx -> IALU.
  - 100xxx -> LOAD.
  - 101xxx -> STORE.
  - Any other opcode -> HALT, exc_cause=1.
  - JUMP goes directly to FETCH with pc_en=1 in the DECODE cycle.
  - All other classes go to EXEC.
- EXEC:
  - RTYPE/IALU with overflow_error=1: HALT, exc_cause=2, no pc_en.
  - RTYPE/IALU with overflow_error=0: WB.
  - BRANCH: pc_en=1, then FETCH. overflow_error is ignored for BRANCH.
  - LOAD/STORE: MEM. Timeout counter cleared on entry.
- MEM: counter increments each cycle mem_ready=0.
  - mem_ready=1, STORE: memWrite=1 for exactly this cycle; pc_en=1; next FETCH.
  - mem_ready=1, LOAD: next WB.
  - memWrite is Mealy: (state==MEM) & STORE & mem_ready.
  - Counter reaching MEM_TIMEOUT with mem_ready still 0: HALT, exc_cause=4, memWrite never asserted.
  - If mem_ready rises on the same cycle the counter reaches MEM_TIMEOUT, the access completes; no halt.
- WB: regWrite=1 for one cycle.
  - reg_access=1 in this cycle: HALT, exc_cause=3, pc_en=0. The datapath write still occurs, since regWrite is already asserted.
  - Otherwise pc_en=1, then FETCH.
- HALT:
  - All strobes 0, halted=1. exc_cause holds.
  - Stays in HALT until reset. Inputs are ignored.
- retired increments by 1 on every cycle pc_en=1 and wraps modulo 2^RETIRE_W.
- Cycles per instruction:
  - JUMP: 2.
  - BRANCH: 3.
  - RTYPE/IALU: 4.
  - STORE: 4+wait.
  - LOAD: 5+wait.
- Reset asserted mid-instruction: immediate return to BOOT. No strobe may glitch high after reset assertion.
- Strobe exclusivity: regWrite and memWrite are never high in the same cycle, and pc_en is never high together with ir_load.

Decomposition:
- Shared package mips_ctrl_pkg holds:
  - State encoding: BOOT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6.
  - Opcode class enum: NONE, RTYPE, BRANCH, JUMP, IALU, LOAD, STORE.
  - exc_cause codes.
  - Opcode pattern constants.
- One combinational sub-module, opcode_classifier (opcode -> class, illegal flag). It is reusable by a future hazard unit.

Test Plan:
- Reset release, opcode=000000, mem_ready=0, flags 0 -> states BOOT,FETCH,DECODE,EXEC,WB,FETCH. regWrite=1 only in WB. pc_en=1 in WB. retired=1 after 5 cycles.
- opcode=101011 (sw), mem_ready low 3 cycles then high -> memWrite=1 exactly one cycle (the ready cycle). pc_en same cycle. regWrite never 1.
- opcode=100011 (lw), mem_ready held 0, MEM_TIMEOUT=4 -> HALT after 4 MEM cycles, exc_cause=4, halted=1, memWrite/regWrite stay 0, retired unchanged.
- opcode=001000, overflow_error=1 in EXEC -> HALT, exc_cause=2, no regWrite, no pc_en. Later flag changes do not leave HALT.
- opcode=111111 -> HALT from DECODE, exc_cause=1. Assert reset for 1 cycle -> state=BOOT, halted=0, exc_cause=0, retired=0.
- opcode=000010 (j) then 000100 (beq) -> jump retires in 2 cycles, branch in 3. retired=2. regWrite and memWrite never asserted.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS control unit:
// FSM state encoding, opcode classes, halt cause codes and opcode patterns.
package mips_ctrl_pkg;

  typedef enum logic [2:0] {
    S_BOOT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  typedef enum logic [2:0] {
    CLS_NONE   = 3'd0,
    CLS_RTYPE  = 3'd1,
    CLS_BRANCH = 3'd2,
    CLS_JUMP   = 3'd3,
    CLS_IALU   = 3'd4,
    CLS_LOAD   = 3'd5,
    CLS_STORE  = 3'd6
  } opclass_t;

  localparam logic [2:0] EXC_NONE     = 3'd0;
  localparam logic [2:0] EXC_ILLEGAL  = 3'd1;
  localparam logic [2:0] EXC_OVERFLOW = 3'd2;
  localparam logic [2:0] EXC_REGERR   = 3'd3;
  localparam logic [2:0] EXC_BUSERR   = 3'd4;

  // Prefixes of opcode[5:0]; x bits are simply not compared.
  localparam logic [5:0] OP_RTYPE  = 6'b000000;
  localparam logic [4:0] OP_BRANCH = 5'b00010;
  localparam logic [4:0] OP_JUMP   = 5'b00001;
  localparam logic [2:0] OP_IALU   = 3'b001;
  localparam logic [2:0] OP_LOAD   = 3'b100;
  localparam logic [2:0] OP_STORE  = 3'b101;

endpackage

// File: rtl/opcode_classifier.sv
// Combinational opcode -> class decoder with illegal-opcode flag.
// Ports: opcode (in 6), o_class (out class), o_illegal (out 1).
module opcode_classifier
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output opclass_t   o_class,
  output logic       o_illegal
);

  always_comb begin
    o_class   = CLS_NONE;
    o_illegal = 1'b0;
    unique case (1'b1)
      (opcode == OP_RTYPE):       o_class = CLS_RTYPE;
      (opcode[5:1] == OP_BRANCH): o_class = CLS_BRANCH;
      (opcode[5:1] == OP_JUMP):   o_class = CLS_JUMP;
      (opcode[5:3] == OP_IALU):   o_class = CLS_IALU;
      (opcode[5:3] == OP_LOAD):   o_class = CLS_LOAD;
      (opcode[5:3] == OP_STORE):  o_class = CLS_STORE;
      default:                    o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky halt.
// Ports: clk, reset, opcode, overflow_error, reg_access, mem_ready in;
// regWrite, memWrite, ir_load, pc_en, state, halted, exc_cause, retired out.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int RETIRE_W    = 32
)(
  input  logic                clk,
  input  logic                reset,
  input  logic [5:0]          opcode,
  input  logic                overflow_error,
  input  logic                reg_access,
  input  logic                mem_ready,
  output logic                regWrite,
  output logic                memWrite,
  output logic                ir_load,
  output logic                pc_en,
  output logic [2:0]          state,
  output logic                halted,
  output logic [2:0]          exc_cause,
  output logic [RETIRE_W-1:0] retired
);

  localparam logic [7:0] TO = 8'(MEM_TIMEOUT);

  state_t               r_state, w_next;
  opclass_t             r_cls, w_cls_d, w_cls;
  logic [2:0]           r_exc, w_exc_d;
  logic [7:0]           r_cnt, w_cnt_d, w_cnt_inc;
  logic [RETIRE_W-1:0]  r_ret;
  logic                 w_illegal;

  opcode_classifier u_cls (
    .opcode    (opcode),
    .o_class   (w_cls),
    .o_illegal (w_illegal)
  );

  assign w_cnt_inc = r_cnt + 8'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_BOOT;
      r_cls   <= CLS_NONE;
      r_exc   <= EXC_NONE;
      r_cnt   <= 8'd0;
      r_ret   <= '0;
    end else begin
      r_state <= w_next;
      r_cls   <= w_cls_d;
      r_exc   <= w_exc_d;
      r_cnt   <= w_cnt_d;
      if (pc_en) r_ret <= r_ret + RETIRE_W'(1);
    end
  end

  always_comb begin
    w_next   = r_state;
    w_cls_d  = r_cls;
    w_exc_d  = r_exc;
    w_cnt_d  = r_cnt;
    regWrite = 1'b0;
    memWrite = 1'b0;
    ir_load  = 1'b0;
    pc_en    = 1'b0;
    unique case (r_state)
      S_BOOT:  w_next = S_FETCH;
      S_FETCH: begin
        ir_load = 1'b1;
        w_next  = S_DECODE;
      end
      S_DECODE: begin
        w_cls_d = w_cls;
        if (w_illegal) begin
          w_cls_d = CLS_NONE;
          w_exc_d = EXC_ILLEGAL;
          w_next  = S_HALT;
        end else if (w_cls == CLS_JUMP) begin
          pc_en  = 1'b1;
          w_next = S_FETCH;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        unique case (r_cls)
          CLS_RTYPE, CLS_IALU: begin
            if (overflow_error) begin
              w_exc_d = EXC_OVERFLOW;
              w_next  = S_HALT;
            end else begin
              w_next = S_WB;
            end
          end
          CLS_BRANCH: begin
            pc_en  = 1'b1;
            w_next = S_FETCH;
          end
          CLS_LOAD, CLS_STORE: begin
            w_cnt_d = 8'd0;
            w_next  = S_MEM;
          end
          default: begin
            // No legal path reaches EXEC without a class.
            w_exc_d = EXC_ILLEGAL;
            w_next  = S_HALT;
          end
        endcase
      end
      S_MEM: begin
        // A ready on the would-be timeout cycle still completes.
        if (mem_ready) begin
          if (r_cls == CLS_STORE) begin
            memWrite = 1'b1;
            pc_en    = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next = S_WB;
          end
        end else if (w_cnt_inc >= TO) begin
          w_cnt_d = w_cnt_inc;
          w_exc_d = EXC_BUSERR;
          w_next  = S_HALT;
        end else begin
          w_cnt_d = w_cnt_inc;
        end
      end
      S_WB: begin
        regWrite = 1'b1;
        if (reg_access) begin
          w_exc_d = EXC_REGERR;
          w_next  = S_HALT;
        end else begin
          pc_en  = 1'b1;
          w_next = S_FETCH;
        end
      end
      S_HALT:  w_next = S_HALT;
      default: w_next = S_BOOT;
    endcase
  end

  assign state     = r_state;
  assign halted    = (r_state == S_HALT);
  assign exc_cause = r_exc;
  assign retired   = r_ret;

endmodule
